// File: rtl/pll_supervisor_pkg.sv
// Shared definitions for the PLL clock supervisor: FSM state encoding and
// default timing constants for a 16 MHz PLL output clock.
package pll_supervisor_pkg;

    // Supervisor FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Nominal operating point: 16 MHz PLL output, 1 MHz timer tick
    localparam int PLL_CLK_HZ = 16_000_000;
    localparam int TICK_HZ    = 1_000_000;

    // Defaults for the supervisor parameters
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_TICK_DIV      = PLL_CLK_HZ / TICK_HZ;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Both stages clear to 0 on the asynchronous active-high reset.
module sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the async input through two flops to resolve metastability
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_clk_supervisor.sv
// PLL lock supervisor: holds RST_OUT until the synchronized LOCK has been
// continuously high for STABLE_CYCLES clocks, re-asserts it and records a
// sticky LOCK_LOST when lock drops in RUN, and optionally generates a
// one-cycle TICK every TICK_DIV clocks while running.
// Build option: define PLL_SUPERVISOR_TICK_EN to include the tick generator;
// without it TICK is tied low and TICK_DIV has no effect.
module pll_clk_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int TICK_DIV      = DEF_TICK_DIV
) (
    input  logic CLK,
    input  logic RESET,
    input  logic LOCK,
    input  logic CLR_LOST,
    output logic RST_OUT,
    output logic READY,
    output logic TICK,
    output logic LOCK_LOST
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Parameter range checks at elaboration
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("STABLE_CYCLES must be >= 1");
    end
    if (TICK_DIV < 2) begin : g_bad_div
        $error("TICK_DIV must be >= 2");
    end

    logic             w_lock_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rst_out;
    logic             r_ready;
    logic             r_lock_lost;

    sync2 u_lock_sync (
        .i_clk (CLK),
        .i_rst (RESET),
        .i_d   (LOCK),
        .o_q   (w_lock_s)
    );

    // Lock FSM with settling counter; RST_OUT/READY are registered alongside
    // the state so they always equal a decode of r_state==RUN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_rst_out <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    r_cnt <= '0;
                    if (w_lock_s) begin
                        r_state <= STABILIZE;
                    end
                end
                STABILIZE: begin
                    if (!w_lock_s) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= RUN;
                        r_cnt     <= '0;
                        r_rst_out <= 1'b0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    r_cnt <= '0;
                    if (!w_lock_s) begin
                        r_state   <= WAIT_LOCK;
                        r_rst_out <= 1'b1;
                        r_ready   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= WAIT_LOCK;
                    r_cnt     <= '0;
                    r_rst_out <= 1'b1;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky lock-lost flag; a new loss wins over a simultaneous clear
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_lock_lost <= 1'b0;
        end else if ((r_state == RUN) && !w_lock_s) begin
            r_lock_lost <= 1'b1;
        end else if (CLR_LOST) begin
            r_lock_lost <= 1'b0;
        end
    end

`ifdef PLL_SUPERVISOR_TICK_EN
    localparam int                TCNT_W    = $clog2(TICK_DIV);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);

    logic [TCNT_W-1:0] r_tcnt;

    // Tick divider: parked at 0 outside RUN so the first tick lands on the
    // TICK_DIV-th running cycle
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_tcnt <= '0;
        end else if (r_state != RUN) begin
            r_tcnt <= '0;
        end else if (r_tcnt == TCNT_LAST) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    assign TICK = (r_state == RUN) && (r_tcnt == TCNT_LAST);
`else
    assign TICK = 1'b0;
`endif

    assign RST_OUT   = r_rst_out;
    assign READY     = r_ready;
    assign LOCK_LOST = r_lock_lost;

endmodule

// File: tb/tb_pll_clk_supervisor.sv
// Directed bench for pll_clk_supervisor with STABLE_CYCLES=8, TICK_DIV=4.
// Outputs are compared as the packed tuple {RST_OUT, READY, TICK, LOCK_LOST}.
module tb_pll_clk_supervisor;

    localparam int STABLE = 8;
    localparam int DIV    = 4;

`ifdef PLL_SUPERVISOR_TICK_EN
    localparam logic TICK_BUILT = 1'b1;
`else
    localparam logic TICK_BUILT = 1'b0;
`endif

    typedef struct {
        logic       lock;
        logic       clr;
        logic [3:0] exp;   // {rst_out, ready, tick, lock_lost}
    } vec_t;

    logic clk;
    logic reset;
    logic lock;
    logic clr_lost;
    logic rst_out;
    logic ready;
    logic tick;
    logic lock_lost;

    int total = 0;
    int bad   = 0;

    vec_t vt[30];

    pll_clk_supervisor #(
        .STABLE_CYCLES (STABLE),
        .TICK_DIV      (DIV)
    ) dut (
        .CLK       (clk),
        .RESET     (reset),
        .LOCK      (lock),
        .CLR_LOST  (clr_lost),
        .RST_OUT   (rst_out),
        .READY     (ready),
        .TICK      (tick),
        .LOCK_LOST (lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare outputs; the tick bit is expected only when the generator is built
    task automatic chk(input string nm, input int idx, input logic [3:0] exp_raw);
        logic [3:0] act;
        logic [3:0] exp;
        act = {rst_out, ready, tick, lock_lost};
        exp = {exp_raw[3:2], exp_raw[1] & TICK_BUILT, exp_raw[0]};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: rst/rdy/tick/lost got %b want %b", nm, idx, act, exp);
        end
    endtask

    initial begin
        // Lock acquisition: 10 settling edges, then RUN with ticks at 4, 8, 12
        for (int i = 0; i < 10; i++) vt[i] = '{1'b1, 1'b0, 4'b1000};
        vt[10] = '{1'b1, 1'b0, 4'b0100};  // RUN cycle 1
        vt[11] = '{1'b1, 1'b0, 4'b0100};
        vt[12] = '{1'b1, 1'b0, 4'b0100};
        vt[13] = '{1'b1, 1'b0, 4'b0110};  // RUN cycle 4
        vt[14] = '{1'b1, 1'b0, 4'b0100};
        vt[15] = '{1'b1, 1'b0, 4'b0100};
        vt[16] = '{1'b1, 1'b0, 4'b0100};
        vt[17] = '{1'b1, 1'b0, 4'b0110};  // RUN cycle 8
        vt[18] = '{1'b1, 1'b0, 4'b0100};
        vt[19] = '{1'b1, 1'b0, 4'b0100};
        vt[20] = '{1'b1, 1'b0, 4'b0100};
        vt[21] = '{1'b1, 1'b0, 4'b0110};  // RUN cycle 12
        vt[22] = '{1'b1, 1'b0, 4'b0100};
        vt[23] = '{1'b1, 1'b0, 4'b0100};  // RUN cycle 14
        // Lock drop in RUN: two edges still running, third edge resets
        vt[24] = '{1'b0, 1'b0, 4'b0100};  // RUN cycle 15
        vt[25] = '{1'b0, 1'b0, 4'b0110};  // RUN cycle 16
        vt[26] = '{1'b0, 1'b1, 4'b1001};  // set beats simultaneous clear
        vt[27] = '{1'b0, 1'b0, 4'b1001};
        vt[28] = '{1'b0, 1'b1, 4'b1000};  // lone clear
        vt[29] = '{1'b0, 1'b0, 4'b1000};

        reset    = 1'b1;
        lock     = 1'b0;
        clr_lost = 1'b0;
        step();
        step();
        chk("reset_state", 0, 4'b1000);
        reset = 1'b0;

        // Idle with LOCK low
        for (int k = 1; k <= 50; k++) begin
            step();
            chk("idle_nolock", k, 4'b1000);
        end

        // Table-driven acquisition, tick, loss and clear
        for (int i = 0; i < 30; i++) begin
            lock     = vt[i].lock;
            clr_lost = vt[i].clr;
            step();
            chk("vec", i, vt[i].exp);
        end
        clr_lost = 1'b0;

        // Glitch during STABILIZE at cnt=5: no fault, full settling restarts
        lock = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("glitch_pre", k, 4'b1000);
        end
        lock = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            step();
            chk("glitch_low", k, 4'b1000);
        end
        lock = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk("glitch_resettle", k, (k < 11) ? 4'b1000 : 4'b0100);
        end

        // Lose lock to set the sticky flag, then relock with the flag still set
        lock = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("drop2", k, (k < 3) ? 4'b0100 : 4'b1001);
        end
        lock = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            chk("relock_sticky", k, (k < 11) ? 4'b1001 : 4'b0101);
        end

        // Asynchronous reset between edges while running
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_now", 0, 4'b1000);
        step();
        chk("async_rst_held", 0, 4'b1000);
        reset = 1'b0;

        // After release with LOCK held: 11 edges to RUN
        for (int k = 1; k <= 11; k++) begin
            step();
            chk("post_rst_settle", k, (k < 11) ? 4'b1000 : 4'b0100);
        end

        // 100 running cycles: tick every 4th cycle of RUN (cycles 2..101)
        for (int k = 1; k <= 100; k++) begin
            step();
            chk("run_ticks", k + 1, (((k + 1) % DIV) == 0) ? 4'b0110 : 4'b0100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
